// File: rtl/dc_video_pkg.sv
// Shared video-capture constants and the line-buffer writer state type.
package dc_video_pkg;
  localparam int W_480 = 720;
  localparam int W_240 = 640;
  localparam int H_480 = 480;
  localparam int H_240 = 240;
  localparam int BUF_LINES_LOG2 = 4;

  typedef enum logic [1:0] {IDLE, ALIGN, FILL, RUN} wr_state_t;
endpackage

// File: rtl/frame_checksum_acc.sv
// Per-frame 16-bit sum of (r+g+b) over every written pixel, latched at frame end.
module frame_checksum_acc (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_en,
  input  logic [23:0] pixel,
  input  logic        latch,
  output logic [15:0] checksum
);
  logic [15:0] acc;
  logic [15:0] add_val;

  always_comb begin
    add_val = '0;
    if (add_en)
      add_val = {8'd0, pixel[23:16]} + {8'd0, pixel[15:8]} + {8'd0, pixel[7:0]};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc      <= '0;
      checksum <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (latch) begin
      // The last pixel's write lands on the latch cycle, so fold it in here.
      checksum <= acc + add_val;
      acc      <= '0;
    end else begin
      acc <= acc + add_val;
    end
  end
endmodule

// File: rtl/line_buffer_writer.sv
// Writes captured pixels into a ring of line slots and signals when output may start.
// Optional WRITE_CHECKSUM_EN adds a per-frame pixel checksum on frame_checksum.
module line_buffer_writer #(
  parameter int BUF_LINES_LOG2 = dc_video_pkg::BUF_LINES_LOG2,
  parameter int START_LINES    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      line_doubler,
  input  logic                      add_line,
  input  logic                      resync,
  input  logic [7:0]                red,
  input  logic [7:0]                green,
  input  logic [7:0]                blue,
  input  logic [11:0]               counterX,
  input  logic [11:0]               counterY,
  output logic [BUF_LINES_LOG2+9:0] wraddress,
  output logic [23:0]               wrdata,
  output logic                      wren,
  output logic                      line_done,
  output logic                      start,
  output logic [15:0]               frame_checksum
);
  import dc_video_pkg::*;

  localparam int CW = (START_LINES > 1) ? $clog2(START_LINES) : 1;

  wr_state_t   state;
  logic [11:0] prev_x;
  logic        prev_doubler;
  logic        add_line_reg;
  logic        last_pending;
  logic [CW-1:0] fill_count;

  logic        add_eff;
  logic [11:0] width;
  logic [11:0] height;
  logic        pixel_event;
  logic        abort;
  logic        write_event;
  logic        line_done_next;

  always_comb begin
    // A new add_line value only counts from the top-left pixel of a frame.
    add_eff        = (counterX == 12'd0 && counterY == 12'd0) ? add_line : add_line_reg;
    width          = line_doubler ? 12'(W_240) : 12'(W_480);
    height         = line_doubler ? (12'(H_240) + {11'd0, add_eff}) : 12'(H_480);
    pixel_event    = (counterX != prev_x) && (counterX < width) && (counterY < height);
    abort          = resync || (line_doubler != prev_doubler);
    write_event    = pixel_event && !abort &&
                     (state == FILL || state == RUN ||
                      (state == ALIGN && counterX == 12'd0 && counterY == 12'd0));
    line_done_next = last_pending && !abort;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      prev_x       <= '0;
      prev_doubler <= 1'b0;
      add_line_reg <= 1'b0;
      last_pending <= 1'b0;
      fill_count   <= '0;
      wren         <= 1'b0;
      wraddress    <= '0;
      wrdata       <= '0;
      line_done    <= 1'b0;
      start        <= 1'b0;
    end else begin
      prev_x       <= counterX;
      prev_doubler <= line_doubler;
      if (counterX == 12'd0 && counterY == 12'd0)
        add_line_reg <= add_line;

      wren <= write_event;
      if (write_event) begin
        wraddress <= {counterY[BUF_LINES_LOG2-1:0], counterX[9:0]};
        wrdata    <= {red, green, blue};
      end
      last_pending <= write_event && (counterX == width - 12'd1);
      line_done    <= line_done_next;

      if (abort) begin
        state      <= IDLE;
        start      <= 1'b0;
        fill_count <= '0;
      end else begin
        case (state)
          IDLE:  state <= ALIGN;
          ALIGN: if (write_event) begin
                   state      <= FILL;
                   fill_count <= '0;
                 end
          FILL:  if (line_done_next) begin
                   if (fill_count == CW'(START_LINES - 1)) begin
                     state <= RUN;
                     start <= 1'b1;
                   end else begin
                     fill_count <= fill_count + 1'b1;
                   end
                 end
          RUN:   start <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef WRITE_CHECKSUM_EN
  logic last_line_reg;

  always_ff @(posedge clock) begin
    if (!reset)
      last_line_reg <= 1'b0;
    else if (write_event)
      last_line_reg <= (counterY == height - 12'd1);
  end

  frame_checksum_acc u_checksum (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == IDLE),
    .add_en   (wren),
    .pixel    (wrdata),
    .latch    (line_done_next && last_line_reg),
    .checksum (frame_checksum)
  );
`else
  assign frame_checksum = '0;
`endif
endmodule

// File: tb/tb_line_buffer_writer.sv
// Randomized bench for line_buffer_writer: frame-level reference model feeds a scoreboard.
module tb_line_buffer_writer;
  localparam int BL = 4;
  localparam int SL = 2;
`ifdef WRITE_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clock = 1'b0, reset = 1'b0;
  logic line_doubler = 1'b0, add_line = 1'b0, resync = 1'b0;
  logic [7:0] red = '0, green = '0, blue = '0;
  logic [11:0] counterX = '0, counterY = '0;
  logic [BL+9:0] wraddress;
  logic [23:0] wrdata;
  logic wren, line_done, start;
  logic [15:0] frame_checksum;

  always #5 clock = ~clock;

  line_buffer_writer #(.BUF_LINES_LOG2(BL), .START_LINES(SL)) dut (
    .clock(clock), .reset(reset), .line_doubler(line_doubler), .add_line(add_line),
    .resync(resync), .red(red), .green(green), .blue(blue),
    .counterX(counterX), .counterY(counterY), .wraddress(wraddress), .wrdata(wrdata),
    .wren(wren), .line_done(line_done), .start(start), .frame_checksum(frame_checksum)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int start_lvl; int chk; } ld_t;
  wr_t exp_wr[$];
  ld_t exp_ld[$];
  int errors = 0;
  int checks = 0;

  // Reference model: alignment, lines completed since alignment, checksum sums.
  int m_prev_x = 0;
  bit m_aligned = 0;
  int m_lines = 0;
  int m_acc = 0;
  int m_chk = 0;
  bit m_add = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic disrupt();
    m_aligned = 0;
    m_lines = 0;
    m_acc = 0;
  endtask

  task automatic pixel(input int x, input int y, input int hold, input bit rs);
    logic [23:0] rgb;
    int w, h;
    @(negedge clock);
    rgb = 24'($urandom);
    counterX = 12'(x);
    counterY = 12'(y);
    {red, green, blue} = rgb;
    resync = rs;
    if (x == 0 && y == 0) m_add = add_line;
    w = line_doubler ? 640 : 720;
    h = line_doubler ? 240 + int'(m_add) : 480;
    if (rs) begin
      disrupt();
    end else if (x != m_prev_x && x < w && y < h && (m_aligned || (x == 0 && y == 0))) begin
      m_aligned = 1;
      exp_wr.push_back('{addr: (y % 16) * 1024 + (x % 1024), data: int'(rgb)});
      m_acc += int'(rgb[23:16]) + int'(rgb[15:8]) + int'(rgb[7:0]);
      if (x == w - 1) begin
        m_lines++;
        if (y == h - 1) begin
          if (CHK_EN) m_chk = m_acc % 65536;
          m_acc = 0;
        end
        exp_ld.push_back('{start_lvl: (m_lines >= SL) ? 1 : 0, chk: m_chk});
      end
    end
    m_prev_x = x;
    repeat (hold - 1) @(negedge clock);
  endtask

  task automatic line(input int y, input int xend);
    for (int x = 0; x <= xend; x++) pixel(x, y, int'($urandom_range(2, 3)), 1'b0);
    pixel(900, y, 4, 1'b0);
  endtask

  task automatic full_line(input int y);
    line(y, line_doubler ? 642 : 722);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wren"}, 32'(wren), 0);
    check({tag, "_line_done"}, 32'(line_done), 0);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_wraddress"}, 32'(wraddress), 0);
    check({tag, "_wrdata"}, 32'(wrdata), 0);
    check({tag, "_checksum"}, 32'(frame_checksum), 0);
  endtask

  // Monitor: every write and every line_done pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (wren) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", 32'(wraddress), 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(wraddress), e.addr);
          check("wr_data", 32'(wrdata), e.data);
        end
      end
      if (line_done) begin
        if (exp_ld.size() == 0) begin
          check("unexpected_line_done_start", 32'(start), 32'hFFFF_FFFF);
        end else begin
          ld_t l;
          l = exp_ld.pop_front();
          check("line_done_start", 32'(start), l.start_lvl);
          check("line_done_checksum", 32'(frame_checksum), l.chk);
        end
      end
    end
  end

  initial begin
    #20000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    settle(4);

    // 720x480: unaligned fragment is ignored, then a sparse frame
    line(3, 30);
    full_line(0);
    full_line(1);
    full_line(2);
    full_line(5);
    full_line(479);
    full_line(480);
    settle(6);

    // 640x241: mode change realigns, add_line only re-evaluated at (0,0)
    @(negedge clock);
    line_doubler = 1'b1;
    disrupt();
    @(posedge clock); #1;
    check("ldchg_start", 32'(start), 0);
    settle(4);
    add_line = 1'b1;
    full_line(0);
    full_line(1);
    full_line(17);
    add_line = 1'b0;
    full_line(239);
    full_line(240);
    full_line(241);
    settle(6);

    // resync in RUN at x=100
    full_line(0);
    full_line(1);
    for (int x = 0; x < 100; x++) pixel(x, 2, 2, 1'b0);
    check("pre_resync_start", 32'(start), 1);
    pixel(100, 2, 1, 1'b1);
    @(posedge clock); #1;
    check("resync_wren", 32'(wren), 0);
    check("resync_start", 32'(start), 0);
    settle(3);
    resync = 1'b0;
    settle(4);
    line(4, 40);
    full_line(0);
    full_line(1);
    settle(6);

    // one-cycle reset mid-line
    for (int x = 0; x <= 50; x++) pixel(x, 2, 2, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    disrupt();
    m_chk = 0;
    @(posedge clock); #1;
    check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b1;
    settle(4);
    line(7, 30);
    full_line(0);
    full_line(1);
    settle(6);

    // line_doubler toggled in RUN: back to 720 wide after realignment
    for (int x = 0; x <= 40; x++) pixel(x, 2, 2, 1'b0);
    check("pre_toggle_start", 32'(start), 1);
    @(negedge clock);
    line_doubler = 1'b0;
    disrupt();
    @(posedge clock); #1;
    check("toggle_wren", 32'(wren), 0);
    check("toggle_start", 32'(start), 0);
    settle(4);
    line(3, 30);
    full_line(0);
    full_line(1);
    settle(10);

    check("leftover_writes", 32'(exp_wr.size()), 0);
    check("leftover_line_done", 32'(exp_ld.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
